// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: loader FSM states, frame sync default and processor opcodes
package prog_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_CHK,
        S_RST1,
        S_BURST,
        S_RST2,
        S_RUN
    } state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    localparam logic [3:0] OP_ALU0 = 4'h0;
    localparam logic [3:0] OP_ALU1 = 4'h1;
    localparam logic [3:0] OP_ALU2 = 4'h2;
    localparam logic [3:0] OP_ALU3 = 4'h3;
    localparam logic [3:0] OP_LD   = 4'h4;
    localparam logic [3:0] OP_ST   = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_OUT  = 4'h7;
    localparam logic [3:0] OP_MOV  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_JC   = 4'hA;
    localparam logic [3:0] OP_JNC  = 4'hB;

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: upstream byte stream plus processor load-port signals
interface prog_loader_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       mem_write;
    logic       PC_reset;
    logic [3:0] instr;
    logic [3:0] portin;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_write, PC_reset, instr, portin, busy, done, err
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_write, PC_reset, instr, portin, busy, done, err
    );

endinterface

// File: rtl/prog_buffer.sv
// prog_buffer: image store, one write port and one asynchronous read port
module prog_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];

    // Contents are only meaningful after a full frame, so no reset is needed
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/prog_loader.sv
// prog_loader: buffers a checked program frame and replays it as a gap-free load burst
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         DEPTH      = 16,
    parameter int         RST_CYCLES = 2,
    parameter logic [7:0] SYNC       = SYNC_DEFAULT
) (
    input logic          clk,
    input logic          rst_n,
    prog_loader_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(RST_CYCLES + 1);

    state_t        state_q;
    logic [AW-1:0] idx_q;
    logic [AW-1:0] bi_q;
    logic [CW-1:0] cnt_q;
    logic [7:0]    acc_q;
    logic [7:0]    word_q;
    logic          mem_write_q;
    logic          pc_reset_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic          take;
    logic          wr_en;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;

    assign bus.in_ready = state_q inside {S_IDLE, S_RECV, S_CHK, S_RUN};
    assign take         = bus.in_valid & bus.in_ready;
    assign wr_en        = take & (state_q == S_RECV);
    // Read one word ahead so the registered output holds word i in its own cycle
    assign rd_addr      = (state_q == S_BURST) ? bi_q + 1'b1 : '0;

    prog_buffer #(.DEPTH(DEPTH)) u_buf (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (idx_q),
        .wdata_i (bus.in_data),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    // Frame parsing, checksum and load sequencing; all processor outputs registered here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            bi_q        <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            word_q      <= '0;
            mem_write_q <= 1'b0;
            pc_reset_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE, S_RUN: if (take && bus.in_data == SYNC) begin
                    state_q <= S_RECV;
                    idx_q   <= '0;
                    acc_q   <= '0;
                end
                S_RECV: if (take) begin
                    acc_q <= acc_q ^ bus.in_data;
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == AW'(DEPTH - 1)) state_q <= S_CHK;
                end
                S_CHK: if (take) begin
                    if (bus.in_data == acc_q) begin
                        state_q    <= S_RST1;
                        cnt_q      <= '0;
                        pc_reset_q <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                    end else begin
                        err_q   <= 1'b1;
                        state_q <= done_q ? S_RUN : S_IDLE;
                    end
                end
                S_RST1: if (cnt_q == CW'(RST_CYCLES - 1)) begin
                    state_q     <= S_BURST;
                    bi_q        <= '0;
                    pc_reset_q  <= 1'b0;
                    mem_write_q <= 1'b1;
                    word_q      <= rd_data;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                S_BURST: if (bi_q == AW'(DEPTH - 1)) begin
                    state_q     <= S_RST2;
                    cnt_q       <= '0;
                    mem_write_q <= 1'b0;
                    pc_reset_q  <= 1'b1;
                    word_q      <= '0;
                end else begin
                    bi_q   <= bi_q + 1'b1;
                    word_q <= rd_data;
                end
                S_RST2: if (cnt_q == CW'(RST_CYCLES - 1)) begin
                    state_q    <= S_RUN;
                    pc_reset_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_write = mem_write_q;
    assign bus.PC_reset  = pc_reset_q;
    assign bus.instr     = word_q[7:4];
    assign bus.portin    = word_q[3:0];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: table-driven frames plus scoreboard on the load burst
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam int D = 16;
    localparam int R = 2;

    typedef struct {
        bit         junk;
        logic [7:0] cs_x;
        int         max_gap;
        bit         exp_err;
        bit         exp_done;
        bit         exp_pcr;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   passed = 0;
    int   total  = 0;

    logic [7:0] prog [D];
    logic [7:0] prog_cs;
    logic [7:0] img [D];
    logic [7:0] exp_q [$];
    int         burst_base = 0;
    int         bk = 0;
    vec_t       vecs [4];

    prog_loader_if bus ();

    prog_loader #(.DEPTH(D), .RST_CYCLES(R), .SYNC(SYNC_DEFAULT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc + 1);
    endtask

    // Scoreboard: every processor write must match the next queued image byte and its slot
    always @(negedge clk) begin
        if (rst_n && bus.mem_write) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {31'b0, bus.mem_write}, 32'd0);
            end else begin
                check("burst_word", {bus.instr, bus.portin}, exp_q.pop_front());
                check("burst_cycle", cyc + 1, burst_base + bk);
                if (bk < D) img[bk] = {bus.instr, bus.portin};
                bk++;
            end
        end
    end

    // Tasks start and end just after a rising edge
    task automatic send_byte(input logic [7:0] b, input int gap, output int t);
        logic rdy;
        t = 0;
        if (gap > 0) begin
            bus.in_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            rdy = bus.in_ready;
            t   = cyc + 1;
            @(posedge clk);
            #1;
            if (rdy) begin
                bus.in_valid = 1'b0;
                return;
            end
        end
        check("accept_timeout", {31'b0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input bit with_sync, input logic [7:0] cs, input int max_gap, output int t);
        int dummy;
        if (with_sync) send_byte(SYNC_DEFAULT, $urandom_range(0, max_gap), dummy);
        for (int i = 0; i < D; i++) send_byte(prog[i], $urandom_range(0, max_gap), dummy);
        if (cs == prog_cs) begin
            for (int i = 0; i < D; i++) begin
                exp_q.push_back(prog[i]);
                img[i] = 8'hxx;
            end
            bk = 0;
        end
        send_byte(cs, $urandom_range(0, max_gap), t);
        burst_base = t + R + 1;
    endtask

    task automatic walk_load(input int t, input int last);
        logic pcr, mw, bsy, dn;
        for (int c = t + 1; c <= last; c++) begin
            @(negedge clk);
            pcr = (c <= t + R) || (c > t + R + D && c <= t + 2 * R + D);
            mw  = (c > t + R) && (c <= t + R + D);
            bsy = (c <= t + 2 * R + D);
            dn  = (c > t + 2 * R + D);
            check("load_seq",
                  {bus.PC_reset, bus.mem_write, bus.busy, bus.done, bus.in_ready, bus.err,
                   {bus.instr, bus.portin} & {8{~mw}}},
                  {pcr, mw, bsy, dn, ~bsy, 1'b0, 8'h00});
            @(posedge clk);
            #1;
        end
    endtask

    task automatic walk_bad(input int t, input bit dn, input bit pcr);
        for (int c = t + 1; c <= t + 3; c++) begin
            @(negedge clk);
            check("bad_cs_seq",
                  {bus.err, bus.mem_write, bus.PC_reset, bus.done, bus.in_ready, bus.busy},
                  {c == t + 1, 1'b0, pcr, dn, 1'b1, 1'b0});
            @(posedge clk);
            #1;
        end
    endtask

    // Minimal processor: only LDI/OUT/JMP matter for the test image
    task automatic run_model();
        int         pc;
        logic [3:0] a;
        logic [3:0] pout;
        logic [7:0] w;
        pc = 0;
        a = 4'h0;
        pout = 4'h0;
        for (int s = 0; s < 8; s++) begin
            w = img[pc];
            if (w[7:4] == OP_LDI) begin
                a = w[3:0];
                pc++;
            end else if (w[7:4] == OP_OUT) begin
                pout = a;
                pc++;
            end else if (w[7:4] == OP_JMP) begin
                pc = int'(w[3:0]);
            end else begin
                pc++;
            end
            pc = pc % D;
        end
        check("portout", {28'b0, pout}, 32'd5);
    endtask

    task automatic check_reset_vals(input string name);
        check(name,
              {bus.mem_write, bus.PC_reset, bus.instr, bus.portin, bus.busy, bus.done, bus.err, bus.in_ready},
              {1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1});
    endtask

    task automatic good_load(input bit with_sync, input int max_gap);
        int t;
        send_frame(with_sync, prog_cs, max_gap, t);
        walk_load(t, t + 2 * R + D + 1);
        check("queue_drained", exp_q.size(), 32'd0);
        run_model();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        int dummy;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        for (int i = 0; i < D; i++) prog[i] = 8'h00;
        prog[0] = {OP_LDI, 4'd5};
        prog[1] = {OP_OUT, 4'd0};
        prog[2] = {OP_JMP, 4'd1};
        prog_cs = 8'h00;
        for (int i = 0; i < D; i++) prog_cs = prog_cs ^ prog[i];

        vecs[0] = '{1'b0, 8'h01, 0, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 8'h00, 5, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 8'h01, 3, 1'b1, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset_vals");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("idle_after_reset");

        foreach (vecs[v]) begin
            if (vecs[v].junk) begin
                send_byte(8'h00, 0, dummy);
                send_byte(8'hFF, 0, dummy);
            end
            send_frame(1'b1, prog_cs ^ vecs[v].cs_x, vecs[v].max_gap, t);
            if (vecs[v].exp_err) begin
                walk_bad(t, vecs[v].exp_done, vecs[v].exp_pcr);
            end else begin
                walk_load(t, t + 2 * R + D + 1);
                check("queue_drained", exp_q.size(), 32'd0);
                run_model();
                @(negedge clk);
                check("post_load", {bus.done, bus.PC_reset}, {vecs[v].exp_done, vecs[v].exp_pcr});
                @(posedge clk);
                #1;
            end
        end

        // SYNC held through the burst must wait for RUN, then start a reload
        send_frame(1'b1, prog_cs, 0, t);
        bus.in_valid = 1'b1;
        bus.in_data  = SYNC_DEFAULT;
        walk_load(t, t + 2 * R + D + 1);
        bus.in_valid = 1'b0;
        check("done_while_reloading", {31'b0, bus.done}, 32'd1);
        good_load(1'b0, 2);

        // Reset during burst word 7, then a full clean load
        send_frame(1'b1, prog_cs, 0, t);
        walk_load(t, t + R + 7);
        rst_n = 1'b0;
        #1;
        check_reset_vals("reset_mid_burst");
        check("words_before_reset", bk, 32'd7);
        exp_q.delete();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        good_load(1'b1, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
